// File: rtl/ahb_apb_bridge_mc_pkg.sv
// Shared AHB encodings and the bridge state enum for the multi-slave AHB-to-APB bridge.
package ahb_apb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_e;
endpackage

// File: rtl/ahb_apb_bridge_mc_decoder.sv
// Window decoder: maps an AHB address onto one of NUM_SLAVES equally sized APB windows.
module apb_addr_decoder #(
    parameter int unsigned       ADDR_W        = 32,
    parameter int unsigned       NUM_SLAVES    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned       SLV_SIZE_LOG2 = 12,
    localparam int unsigned      IDX_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0] haddr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] slot;

    // Subtraction wraps; the >= compare rejects addresses below the window.
    assign offset = haddr_i - BASE_ADDR;
    assign slot   = offset >> SLV_SIZE_LOG2;
    assign hit_o  = (haddr_i >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLAVES));
    assign idx_o  = slot[IDX_W-1:0];
endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave to NUM_SLAVES APB slaves with wait states, error mapping,
// pready timeout and back-to-back transfers.
module ahb_apb_bridge_mc
    import ahb_apb_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 32,
    parameter int unsigned       DATA_W        = 32,
    parameter int unsigned       NUM_SLAVES    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned       SLV_SIZE_LOG2 = 12,
    parameter int unsigned       TIMEOUT       = 16
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    input  logic                         hwrite,
    input  logic [DATA_W-1:0]            hwdata,
    input  logic                         hready_in,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready_out,
    output logic [1:0]                   hresp,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    output logic                         pwrite,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES-1:0]        pslverr
);
    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              xfer_req;
    logic              can_accept;
    logic              sel_ready;
    logic              sel_err;
    logic              timed_out;

    apb_addr_decoder #(
        .ADDR_W       (ADDR_W),
        .NUM_SLAVES   (NUM_SLAVES),
        .BASE_ADDR    (BASE_ADDR),
        .SLV_SIZE_LOG2(SLV_SIZE_LOG2)
    ) u_dec (
        .haddr_i(haddr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    assign xfer_req  = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign sel_ready = pready[idx_q];
    assign sel_err   = pslverr[idx_q];
    // cnt_q counts completed ACCESS cycles, so TIMEOUT-1 marks the last allowed one.
    assign timed_out = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        cnt_d      = '0;
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        hrdata     = '0;
        can_accept = 1'b0;
        case (state_q)
            IDLE:  can_accept = 1'b1;
            WDATA: begin
                hready_out = 1'b0;
                wdata_d    = hwdata;
                state_d    = SETUP;
            end
            SETUP: begin
                hready_out = 1'b0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_ready && sel_err) begin
                    hready_out = 1'b0;
                    state_d    = ERR1;
                end else if (sel_ready) begin
                    can_accept = 1'b1;
                    if (!write_q)
                        hrdata = prdata[idx_q*DATA_W +: DATA_W];
                end else begin
                    hready_out = 1'b0;
                    if (timed_out)
                        state_d = ERR1;
                end
            end
            ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
                state_d    = ERR2;
            end
            ERR2: begin
                hresp      = HRESP_ERROR;
                can_accept = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Shared address-phase acceptance for IDLE, ERR2 and an ACCESS completion.
        if (can_accept) begin
            state_d = IDLE;
            if (hready_in && xfer_req) begin
                addr_d  = haddr;
                write_d = hwrite;
                if (dec_hit) begin
                    idx_d   = dec_idx;
                    state_d = hwrite ? WDATA : SETUP;
                end else begin
                    state_d = ERR1;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            psel[i] = ((state_q == SETUP) || (state_q == ACCESS)) && (idx_q == IDX_W'(i));
    end

    assign penable = (state_q == ACCESS);
    assign paddr   = addr_q;
    assign pwrite  = write_q;
    assign pwdata  = wdata_q;
endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Self-checking bench for ahb_apb_bridge_mc: vector table with scoreboard plus multi-cycle sequences.
module tb_ahb_apb_bridge_mc;
    import ahb_apb_pkg::*;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic           hclk = 1'b0;
    logic           hreset;
    logic [AW-1:0]  haddr;
    logic [1:0]     htrans;
    logic           hwrite;
    logic [DW-1:0]  hwdata;
    logic           hready_in;
    logic [DW-1:0]  hrdata;
    logic           hready_out;
    logic [1:0]     hresp;
    logic [AW-1:0]  paddr;
    logic [DW-1:0]  pwdata;
    logic           pwrite;
    logic [NS-1:0]  psel;
    logic           penable;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]  pready;
    logic [NS-1:0]  pslverr;

    ahb_apb_bridge_mc #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .NUM_SLAVES   (NS),
        .BASE_ADDR    (32'h8000_0000),
        .SLV_SIZE_LOG2(12),
        .TIMEOUT      (4)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hready_in (hready_in),
        .hrdata    (hrdata),
        .hready_out(hready_out),
        .hresp     (hresp),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 hclk = ~hclk;
    assign hready_in = hready_out;

    // APB slave model: selected slave waits cur_waits ACCESS cycles; unselected
    // slaves drive the opposite ready/error to prove they are ignored.
    int          cur_waits = 0;
    logic        cur_err   = 1'b0;
    logic [DW-1:0] slv_data [NS];
    int          acc_cnt   = 0;

    always @(posedge hclk) acc_cnt <= penable ? acc_cnt + 1 : 0;
    assign pready  = (acc_cnt >= cur_waits) ? {NS{1'b1}} : ~psel;
    assign pslverr = cur_err ? psel : ~psel;
    for (genvar g = 0; g < NS; g++) begin : g_prd
        assign prdata[g*DW +: DW] = slv_data[g];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        err;
        logic [3:0]  e_psel;
        int          e_cyc;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        int          e_pen;
    } vec_t;

    vec_t vecs [11];
    vec_t sb [$];

    task automatic run_vec(input vec_t v, input int n);
        logic [3:0]  psel_or;
        int          pen_n;
        int          cyc;
        logic [1:0]  prev_resp;
        logic [1:0]  fin_resp;
        logic [31:0] fin_rdata;
        logic [31:0] seen_paddr;
        logic [31:0] seen_pwdata;
        logic        seen_pwrite;
        bit          done;
        vec_t        e;
        cur_waits = v.waits;
        cur_err   = v.err;
        for (int i = 0; i < NS; i++) slv_data[i] = 32'hBAD0_0000 | i;
        for (int j = 0; j < NS; j++) if (v.e_psel[j]) slv_data[j] = v.rdata;
        sb.push_back(v);
        htrans = HTRANS_NONSEQ;
        haddr  = v.addr;
        hwrite = v.wr;
        step();
        htrans = HTRANS_IDLE;
        hwdata = v.wdata;
        psel_or = '0; pen_n = 0; cyc = 0; prev_resp = 2'b11; done = 0;
        fin_resp = 2'b11; fin_rdata = '1;
        seen_paddr = '0; seen_pwdata = '0; seen_pwrite = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge hclk);
            cyc++;
            psel_or |= psel;
            if (penable) begin
                pen_n++;
                seen_paddr  = paddr;
                seen_pwdata = pwdata;
                seen_pwrite = pwrite;
            end
            if (hready_out) begin
                done      = 1;
                fin_resp  = hresp;
                fin_rdata = hrdata;
            end else begin
                prev_resp = hresp;
            end
            step();
        end
        e = sb.pop_front();
        check($sformatf("v%0d completed", n), 32'(done), 32'd1);
        check($sformatf("v%0d data-phase cycles", n), 32'(cyc), 32'(e.e_cyc));
        check($sformatf("v%0d hresp", n), 32'(fin_resp), 32'(e.e_resp));
        check($sformatf("v%0d hrdata", n), fin_rdata, e.e_rdata);
        check($sformatf("v%0d psel", n), 32'(psel_or), 32'(e.e_psel));
        check($sformatf("v%0d penable cycles", n), 32'(pen_n), 32'(e.e_pen));
        if (e.e_resp == HRESP_ERROR)
            check($sformatf("v%0d ERR1 hresp", n), 32'(prev_resp), 32'(HRESP_ERROR));
        if (e.e_pen > 0) begin
            check($sformatf("v%0d paddr", n), seen_paddr, e.addr);
            check($sformatf("v%0d pwrite", n), 32'(seen_pwrite), 32'(e.wr));
            if (e.wr) check($sformatf("v%0d pwdata", n), seen_pwdata, e.wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr          wr    wdata          rdata         w    err   psel     cyc resp         e_rdata       pen
        vecs[0]  = '{32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 32'h0,        0,   1'b0, 4'b0010, 3, HRESP_OKAY,  32'h0,        1};
        vecs[1]  = '{32'h8000_3000, 1'b0, 32'h0,        32'h0000_0019, 2,   1'b0, 4'b1000, 4, HRESP_OKAY,  32'h0000_0019, 3};
        vecs[2]  = '{32'h8000_0000, 1'b0, 32'h0,        32'h1234_5678, 0,   1'b0, 4'b0001, 2, HRESP_OKAY,  32'h1234_5678, 1};
        vecs[3]  = '{32'h7FFF_FFFC, 1'b0, 32'h0,        32'h0,        0,   1'b0, 4'b0000, 2, HRESP_ERROR, 32'h0,        0};
        vecs[4]  = '{32'h8000_4000, 1'b1, 32'h55AA_55AA, 32'h0,        0,   1'b0, 4'b0000, 2, HRESP_ERROR, 32'h0,        0};
        vecs[5]  = '{32'h8000_1000, 1'b1, 32'h0BAD_F00D, 32'h0,        0,   1'b1, 4'b0010, 5, HRESP_ERROR, 32'h0,        1};
        vecs[6]  = '{32'h8000_2FFC, 1'b0, 32'h0,        32'hCAFE_F00D, 1,   1'b0, 4'b0100, 3, HRESP_OKAY,  32'hCAFE_F00D, 2};
        vecs[7]  = '{32'h8000_2000, 1'b0, 32'h0,        32'h0,        100, 1'b0, 4'b0100, 7, HRESP_ERROR, 32'h0,        4};
        vecs[8]  = '{32'h8000_3FFC, 1'b1, 32'h0F0F_1234, 32'h0,        3,   1'b0, 4'b1000, 6, HRESP_OKAY,  32'h0,        4};
        vecs[9]  = '{32'h0000_0000, 1'b0, 32'h0,        32'h0,        0,   1'b0, 4'b0000, 2, HRESP_ERROR, 32'h0,        0};
        vecs[10] = '{32'h8000_0FFC, 1'b1, 32'h1357_9BDF, 32'h0,        0,   1'b0, 4'b0001, 3, HRESP_OKAY,  32'h0,        1};

        for (int i = 0; i < NS; i++) slv_data[i] = '0;
        hreset = 1'b1;
        htrans = HTRANS_IDLE;
        haddr  = '0;
        hwrite = 1'b0;
        hwdata = '0;
        repeat (3) @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("reset hready_out", 32'(hready_out), 32'd1);
        check("reset hresp", 32'(hresp), 32'(HRESP_OKAY));
        check("reset hrdata", hrdata, 32'h0);
        check("reset psel", 32'(psel), 32'h0);
        check("reset penable", 32'(penable), 32'h0);
        check("reset paddr", paddr, 32'h0);
        check("reset pwdata", pwdata, 32'h0);
        check("reset pwrite", 32'(pwrite), 32'h0);

        // BUSY in the window is ignored
        step();
        htrans = HTRANS_BUSY;
        haddr  = 32'h8000_1000;
        step();
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        check("busy psel", 32'(psel), 32'h0);
        check("busy hready_out", 32'(hready_out), 32'd1);
        check("busy hresp", 32'(hresp), 32'(HRESP_OKAY));
        step();

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // back-to-back: write then read accepted in the ACCESS completion cycle
        cur_waits = 0;
        cur_err   = 1'b0;
        slv_data[2] = 32'h2222_AAAA;
        htrans = HTRANS_NONSEQ; haddr = 32'h8000_0000; hwrite = 1'b1;
        step();
        htrans = HTRANS_IDLE; hwdata = 32'h1111_2222;
        step();
        step();
        htrans = HTRANS_NONSEQ; haddr = 32'h8000_2000; hwrite = 1'b0;
        @(negedge hclk);
        check("b2b wr done hready", 32'(hready_out), 32'd1);
        check("b2b wr psel", 32'(psel), 32'b0001);
        check("b2b wr penable", 32'(penable), 32'd1);
        check("b2b wr pwdata", pwdata, 32'h1111_2222);
        step();
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        check("b2b rd setup psel", 32'(psel), 32'b0100);
        check("b2b rd setup penable", 32'(penable), 32'd0);
        check("b2b rd paddr", paddr, 32'h8000_2000);
        check("b2b rd pwrite", 32'(pwrite), 32'd0);
        step();
        @(negedge hclk);
        check("b2b rd hready", 32'(hready_out), 32'd1);
        check("b2b rd hrdata", hrdata, 32'h2222_AAAA);
        step();

        // pslverr, then a NONSEQ issued during ERR2
        cur_err = 1'b1;
        slv_data[1] = 32'h0000_0101;
        htrans = HTRANS_NONSEQ; haddr = 32'h8000_1000; hwrite = 1'b1;
        step();
        htrans = HTRANS_IDLE; hwdata = 32'h77;
        step();
        step();
        @(negedge hclk);
        check("slverr access hready", 32'(hready_out), 32'd0);
        step();
        @(negedge hclk);
        check("slverr ERR1 hresp", 32'(hresp), 32'(HRESP_ERROR));
        check("slverr ERR1 hready", 32'(hready_out), 32'd0);
        check("slverr ERR1 psel", 32'(psel), 32'h0);
        check("slverr ERR1 penable", 32'(penable), 32'd0);
        step();
        htrans = HTRANS_NONSEQ; haddr = 32'h8000_1000; hwrite = 1'b0;
        cur_err = 1'b0;
        @(negedge hclk);
        check("slverr ERR2 hresp", 32'(hresp), 32'(HRESP_ERROR));
        check("slverr ERR2 hready", 32'(hready_out), 32'd1);
        step();
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        check("after ERR2 setup psel", 32'(psel), 32'b0010);
        check("after ERR2 setup hresp", 32'(hresp), 32'(HRESP_OKAY));
        step();
        @(negedge hclk);
        check("after ERR2 hready", 32'(hready_out), 32'd1);
        check("after ERR2 hresp", 32'(hresp), 32'(HRESP_OKAY));
        check("after ERR2 hrdata", hrdata, 32'h0000_0101);
        step();

        // reset asserted in ACCESS
        cur_waits = 100;
        htrans = HTRANS_NONSEQ; haddr = 32'h8000_3000; hwrite = 1'b0;
        step();
        htrans = HTRANS_IDLE;
        step();
        @(negedge hclk);
        check("pre-reset penable", 32'(penable), 32'd1);
        step();
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        @(negedge hclk);
        check("midreset psel", 32'(psel), 32'h0);
        check("midreset penable", 32'(penable), 32'd0);
        check("midreset hready", 32'(hready_out), 32'd1);
        check("midreset hresp", 32'(hresp), 32'(HRESP_OKAY));
        step();
        @(negedge hclk);
        check("post-reset hresp", 32'(hresp), 32'(HRESP_OKAY));
        check("post-reset psel", 32'(psel), 32'h0);
        cur_waits = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
